// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: widths, ALU-op encodings,
// bypass-select codes and the bypass priority helper.
package id_ex_operand_stage_pkg;

  localparam int WIDTH = 16;
  localparam int REGW  = 3;
  localparam int OPW   = 3;

  typedef enum logic [OPW-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } aluOp_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwdSel_e;

  localparam logic [REGW-1:0] REG_ZERO = 3'd0;

  // $0 is never bypassed; the younger producer (EX/MEM) beats MEM/WB.
  function automatic fwdSel_e fwdSelect(
    input logic [REGW-1:0] src,
    input logic            exmemWe,
    input logic [REGW-1:0] exmemRd,
    input logic            memwbWe,
    input logic [REGW-1:0] memwbRd
  );
    fwdSel_e sel;
    if (src == REG_ZERO) begin
      sel = FWD_REG;
    end else if (exmemWe && (exmemRd == src)) begin
      sel = FWD_EXMEM;
    end else if (memwbWe && (memwbRd == src)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_forward_mux.sv
// Bypass multiplexer for one source operand: picks the newest in-flight value
// of the source register, falling back to the registered register-file read.
module id_ex_operand_stage_forward_mux
  import id_ex_operand_stage_pkg::*;
(
  input  logic [REGW-1:0]  src,
  input  logic [WIDTH-1:0] regVal,
  input  logic             exmemWe,
  input  logic [REGW-1:0]  exmemRd,
  input  logic [WIDTH-1:0] exmemResult,
  input  logic             memwbWe,
  input  logic [REGW-1:0]  memwbRd,
  input  logic [WIDTH-1:0] memwbResult,
  output logic [WIDTH-1:0] fwdVal
);

  fwdSel_e sel_s;

  // Choose the bypass source by priority.
  always_comb begin
    sel_s = fwdSelect(src, exmemWe, exmemRd, memwbWe, memwbRd);
  end

  // Steer the selected value onto the operand.
  always_comb begin
    fwdVal = regVal;
    case (sel_s)
      FWD_EXMEM: fwdVal = exmemResult;
      FWD_MEMWB: fwdVal = memwbResult;
      FWD_REG:   fwdVal = regVal;
      default:   fwdVal = regVal;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall/bubble
// insertion and a saturating stall-cycle counter.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REGW-1:0]  id_rs,
  input  logic [REGW-1:0]  id_rt,
  input  logic [REGW-1:0]  id_rd,
  input  logic [WIDTH-1:0] id_rs_val,
  input  logic [WIDTH-1:0] id_rt_val,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_use_imm,
  input  logic [OPW-1:0]   id_alu_op,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_reg_write,
  input  logic             flush,
  input  logic             exmem_reg_write,
  input  logic [REGW-1:0]  exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_reg_write,
  input  logic [REGW-1:0]  memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic             stall,
  output logic             ex_valid,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [OPW-1:0]   ex_alu_op,
  output logic [REGW-1:0]  ex_rd,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic [15:0]      stall_count
);

  logic             exValid_r;
  logic             exMemRead_r;
  logic             exMemWrite_r;
  logic             exRegWrite_r;
  logic             exUseImm_r;
  logic [REGW-1:0]  exRs_r;
  logic [REGW-1:0]  exRt_r;
  logic [REGW-1:0]  exRd_r;
  logic [WIDTH-1:0] exRsVal_r;
  logic [WIDTH-1:0] exRtVal_r;
  logic [WIDTH-1:0] exImm_r;
  logic [OPW-1:0]   exAluOp_r;
  logic [15:0]      stallCount_r;

  logic             stall_s;
  logic             nextValid_s;
  logic             rsHit_s;
  logic             rtHit_s;
  logic [WIDTH-1:0] fwdRs_s;
  logic [WIDTH-1:0] fwdRt_s;
  logic [WIDTH-1:0] opY_s;

  // Load-use hazard detection; a taken branch kills the consumer instead.
  always_comb begin
    rsHit_s = (exRd_r == id_rs);
    rtHit_s = (exRd_r == id_rt) & (~id_use_imm | id_mem_write);
    if (flush) begin
      stall_s = 1'b0;
    end else begin
      stall_s = id_valid & exValid_r & exMemRead_r & (exRd_r != REG_ZERO) & (rsHit_s | rtHit_s);
    end
    nextValid_s = id_valid & ~stall_s & ~flush;
  end

  // Pipeline register; control bits are pre-gated so a bubble reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      exValid_r    <= 1'b0;
      exMemRead_r  <= 1'b0;
      exMemWrite_r <= 1'b0;
      exRegWrite_r <= 1'b0;
      exUseImm_r   <= 1'b0;
      exRs_r       <= 3'd0;
      exRt_r       <= 3'd0;
      exRd_r       <= 3'd0;
      exRsVal_r    <= 16'h0000;
      exRtVal_r    <= 16'h0000;
      exImm_r      <= 16'h0000;
      exAluOp_r    <= 3'd0;
    end else begin
      exValid_r    <= nextValid_s;
      exMemRead_r  <= id_mem_read & nextValid_s;
      exMemWrite_r <= id_mem_write & nextValid_s;
      exRegWrite_r <= id_reg_write & nextValid_s;
      exUseImm_r   <= id_use_imm;
      exRs_r       <= id_rs;
      exRt_r       <= id_rt;
      exRd_r       <= id_rd;
      exRsVal_r    <= id_rs_val;
      exRtVal_r    <= id_rt_val;
      exImm_r      <= id_imm;
      exAluOp_r    <= id_alu_op;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount_r <= 16'h0000;
    end else if (stall_s && (stallCount_r != 16'hFFFF)) begin
      stallCount_r <= stallCount_r + 16'h0001;
    end else begin
      stallCount_r <= stallCount_r;
    end
  end

  id_ex_operand_stage_forward_mux uFwdRs (
    .src         (exRs_r),
    .regVal      (exRsVal_r),
    .exmemWe     (exmem_reg_write),
    .exmemRd     (exmem_rd),
    .exmemResult (exmem_result),
    .memwbWe     (memwb_reg_write),
    .memwbRd     (memwb_rd),
    .memwbResult (memwb_result),
    .fwdVal      (fwdRs_s)
  );

  id_ex_operand_stage_forward_mux uFwdRt (
    .src         (exRt_r),
    .regVal      (exRtVal_r),
    .exmemWe     (exmem_reg_write),
    .exmemRd     (exmem_rd),
    .exmemResult (exmem_result),
    .memwbWe     (memwb_reg_write),
    .memwbRd     (memwb_rd),
    .memwbResult (memwb_result),
    .fwdVal      (fwdRt_s)
  );

  // Second ALU operand: immediate or forwarded rt.
  always_comb begin
    if (exUseImm_r) begin
      opY_s = exImm_r;
    end else begin
      opY_s = fwdRt_s;
    end
  end

  assign stall         = stall_s;
  assign ex_valid      = exValid_r;
  assign X             = fwdRs_s;
  assign Y             = opY_s;
  assign ex_store_data = fwdRt_s;
  assign ex_alu_op     = exAluOp_r;
  assign ex_rd         = exRd_r;
  assign ex_mem_read   = exMemRead_r;
  assign ex_mem_write  = exMemWrite_r;
  assign ex_reg_write  = exRegWrite_r;
  assign stall_count   = stallCount_r;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed-vector bench for id_ex_operand_stage with hand-computed expectations.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [REGW-1:0]  id_rs, id_rt, id_rd;
  logic [WIDTH-1:0] id_rs_val, id_rt_val, id_imm;
  logic             id_use_imm;
  logic [OPW-1:0]   id_alu_op;
  logic             id_mem_read, id_mem_write, id_reg_write;
  logic             flush;
  logic             exmem_reg_write;
  logic [REGW-1:0]  exmem_rd;
  logic [WIDTH-1:0] exmem_result;
  logic             memwb_reg_write;
  logic [REGW-1:0]  memwb_rd;
  logic [WIDTH-1:0] memwb_result;
  logic             stall, ex_valid;
  logic [WIDTH-1:0] X, Y, ex_store_data;
  logic [OPW-1:0]   ex_alu_op;
  logic [REGW-1:0]  ex_rd;
  logic             ex_mem_read, ex_mem_write, ex_reg_write;
  logic [15:0]      stall_count;

  int nVectors = 0;
  int nMiscompares = 0;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .ex_valid(ex_valid), .X(X), .Y(Y), .ex_store_data(ex_store_data),
    .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic driveId(input logic v, input logic [2:0] rs, input logic [15:0] rsv,
                         input logic [2:0] rt, input logic [15:0] rtv, input logic [2:0] rd,
                         input logic [15:0] imm, input logic ui, input logic [2:0] op,
                         input logic mr, input logic mw, input logic rw);
    id_valid = v; id_rs = rs; id_rs_val = rsv; id_rt = rt; id_rt_val = rtv; id_rd = rd;
    id_imm = imm; id_use_imm = ui; id_alu_op = op;
    id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
  endtask

  task automatic clrBypass();
    exmem_reg_write = 1'b0; exmem_rd = 3'd0; exmem_result = 16'h0000;
    memwb_reg_write = 1'b0; memwb_rd = 3'd0; memwb_result = 16'h0000;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    clrBypass();
    driveId(1'b1, 3'd2, 16'hAAAA, 3'd3, 16'hBBBB, 3'd5, 16'h1111, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b1);
    step();
    #1;
    checkVal("rst_valid", {31'd0, ex_valid}, 32'd0);
    checkVal("rst_X", {16'd0, X}, 32'd0);
    checkVal("rst_Y", {16'd0, Y}, 32'd0);
    checkVal("rst_cnt", {16'd0, stall_count}, 32'd0);
    checkVal("rst_rw", {31'd0, ex_reg_write}, 32'd0);
    checkVal("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    // EX/MEM vs MEM/WB forwarding
    driveId(1'b1, 3'd2, 16'h0111, 3'd3, 16'h0333, 3'd5, 16'h0000, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1);
    step();
    exmem_reg_write = 1'b1; exmem_rd = 3'd2; exmem_result = 16'h0005;
    memwb_reg_write = 1'b1; memwb_rd = 3'd2; memwb_result = 16'h0009;
    #1;
    checkVal("fwd_exmem_X", {16'd0, X}, 32'h0005);
    checkVal("fwd_Y_nomatch", {16'd0, Y}, 32'h0333);
    checkVal("fwd_valid", {31'd0, ex_valid}, 32'd1);
    checkVal("fwd_rd", {29'd0, ex_rd}, 32'd5);
    checkVal("fwd_rw", {31'd0, ex_reg_write}, 32'd1);
    exmem_reg_write = 1'b0;
    #1;
    checkVal("fwd_memwb_X", {16'd0, X}, 32'h0009);
    memwb_rd = 3'd3;
    #1;
    checkVal("fwd_reg_X", {16'd0, X}, 32'h0111);
    checkVal("fwd_memwb_Y", {16'd0, Y}, 32'h0009);
    checkVal("fwd_store", {16'd0, ex_store_data}, 32'h0009);
    clrBypass();

    // SLT operands, no forwarding
    driveId(1'b1, 3'd1, 16'hFFFE, 3'd3, 16'h0003, 3'd6, 16'h0000, 1'b0, ALU_SLT, 1'b0, 1'b0, 1'b1);
    step();
    checkVal("slt_X", {16'd0, X}, 32'hFFFE);
    checkVal("slt_Y", {16'd0, Y}, 32'h0003);
    checkVal("slt_op", {29'd0, ex_alu_op}, 32'd4);

    // Immediate on Y, store data still forwarded rt
    driveId(1'b1, 3'd1, 16'h0010, 3'd3, 16'h0003, 3'd0, 16'h0042, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0);
    step();
    memwb_reg_write = 1'b1; memwb_rd = 3'd3; memwb_result = 16'h7777;
    #1;
    checkVal("imm_Y", {16'd0, Y}, 32'h0042);
    checkVal("imm_store", {16'd0, ex_store_data}, 32'h7777);
    checkVal("imm_mw", {31'd0, ex_mem_write}, 32'd1);
    clrBypass();

    // Load-use: lw $4 then a consumer of $4
    driveId(1'b1, 3'd1, 16'h0100, 3'd2, 16'h0000, 3'd4, 16'h0004, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1);
    step();
    driveId(1'b1, 3'd4, 16'h00AA, 3'd6, 16'h0066, 3'd7, 16'h0000, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1);
    #1;
    checkVal("lu_stall", {31'd0, stall}, 32'd1);
    checkVal("lu_mr", {31'd0, ex_mem_read}, 32'd1);
    step();
    checkVal("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    checkVal("lu_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
    checkVal("lu_bubble_mr", {31'd0, ex_mem_read}, 32'd0);
    checkVal("lu_stall_drop", {31'd0, stall}, 32'd0);
    checkVal("lu_cnt1", {16'd0, stall_count}, 32'd1);
    step();
    exmem_reg_write = 1'b1; exmem_rd = 3'd4; exmem_result = 16'hBEEF;
    #1;
    checkVal("lu_consumer_valid", {31'd0, ex_valid}, 32'd1);
    checkVal("lu_fwd_X", {16'd0, X}, 32'hBEEF);
    checkVal("lu_cnt_hold", {16'd0, stall_count}, 32'd1);
    clrBypass();

    // $0 guard: never forwarded, and a load to $0 causes no stall
    exmem_reg_write = 1'b1; exmem_rd = 3'd0; exmem_result = 16'h1234;
    memwb_reg_write = 1'b1; memwb_rd = 3'd0; memwb_result = 16'h5678;
    driveId(1'b1, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1);
    step();
    checkVal("zero_X", {16'd0, X}, 32'h0000);
    checkVal("zero_store", {16'd0, ex_store_data}, 32'h0000);
    driveId(1'b1, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd1, 16'h0000, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1);
    #1;
    checkVal("zero_nostall", {31'd0, stall}, 32'd0);
    clrBypass();

    // Flush beats a load-use hazard
    driveId(1'b1, 3'd1, 16'h0100, 3'd2, 16'h0000, 3'd4, 16'h0004, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1);
    step();
    driveId(1'b1, 3'd4, 16'h00AA, 3'd6, 16'h0066, 3'd7, 16'h0000, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    #1;
    checkVal("flush_nostall", {31'd0, stall}, 32'd0);
    step();
    flush = 1'b0;
    checkVal("flush_valid", {31'd0, ex_valid}, 32'd0);
    checkVal("flush_cnt", {16'd0, stall_count}, 32'd1);

    // rt hazard only counts when rt is read (R-type) or stored
    driveId(1'b1, 3'd1, 16'h0100, 3'd2, 16'h0000, 3'd5, 16'h0004, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1);
    step();
    driveId(1'b1, 3'd1, 16'h0000, 3'd5, 16'h0055, 3'd0, 16'h0008, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0);
    #1;
    checkVal("rt_imm_nostall", {31'd0, stall}, 32'd0);
    id_mem_write = 1'b1;
    #1;
    checkVal("rt_store_stall", {31'd0, stall}, 32'd1);
    step();
    checkVal("rt_cnt2", {16'd0, stall_count}, 32'd2);
    checkVal("rt_bubble_mw", {31'd0, ex_mem_write}, 32'd0);

    // Synchronous reset mid-hazard clears everything
    driveId(1'b1, 3'd1, 16'h0100, 3'd2, 16'h0000, 3'd3, 16'h0004, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1);
    step();
    driveId(1'b1, 3'd3, 16'h0033, 3'd6, 16'h0066, 3'd7, 16'h0000, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1);
    #1;
    checkVal("rst2_pre_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    step();
    checkVal("rst2_valid", {31'd0, ex_valid}, 32'd0);
    checkVal("rst2_cnt", {16'd0, stall_count}, 32'd0);
    checkVal("rst2_X", {16'd0, X}, 32'd0);
    checkVal("rst2_mr", {31'd0, ex_mem_read}, 32'd0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
